snapshot_playback: RTL and testbench



---
 rtl/snapshot_playback.sv | 160 ++++++++++++++++
 tb/tb_snapshot_playback.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/snapshot_playback.sv
// Replays software-loaded test vectors onto the wide data bus in place of the live source.
// 32-bit load words are packed into lines in RAM, then streamed one line per data_ce after arm+trigger.
module snapshot_playback #(
    parameter int unsigned DATA_BUS_WIDTH      = 1024,
    parameter int unsigned PLAYBACK_DEPTH      = 1024,
    parameter int unsigned LOG2_PLAYBACK_DEPTH = 10
) (
    input  logic                           clk_data,
    input  logic                           rst,
    input  logic                           load_valid,
    input  logic [31:0]                    load_data,
    output logic                           load_ready,
    input  logic                           clear,
    input  logic                           arm,
    input  logic                           trigger,
    input  logic                           loop_en,
    input  logic                           abort,
    input  logic                           data_ce,
    output logic [DATA_BUS_WIDTH-1:0]      data_out,
    output logic                           data_out_valid,
    output logic                           busy,
    output logic                           done,
    output logic [LOG2_PLAYBACK_DEPTH:0]   load_count
);

    localparam int unsigned DW             = DATA_BUS_WIDTH;
    localparam int unsigned AW             = LOG2_PLAYBACK_DEPTH;
    localparam int unsigned CNT_W          = LOG2_PLAYBACK_DEPTH + 1;
    localparam int unsigned WORDS_PER_LINE = DATA_BUS_WIDTH / 32;
    localparam int unsigned PACK_W         = (WORDS_PER_LINE > 1) ? $clog2(WORDS_PER_LINE) : 1;

    typedef enum logic [1:0] {IDLE, WAIT_TRIG, PLAY, DRAIN} state_t;

    state_t            state;
    logic [AW-1:0]     wr_addr;
    logic [AW-1:0]     rd_addr;
    logic [PACK_W-1:0] pack_cnt;
    logic [DW-1:0]     pack_line;
    logic [DW-1:0]     wr_line;
    logic [DW-1:0]     ram_q;
    logic              loop_q;
    logic              rd_vld;
    logic              drain_cnt;
    logic              load_acc;
    logic              line_done;
    logic              ram_re;
    logic              last_rd;

    logic [DW-1:0] mem [PLAYBACK_DEPTH];

    assign load_ready = (state == IDLE) && (load_count < CNT_W'(PLAYBACK_DEPTH));
    assign load_acc   = load_valid && load_ready && !abort && !clear && !arm;
    assign line_done  = load_acc && (pack_cnt == PACK_W'(WORDS_PER_LINE - 1));
    assign ram_re     = (state == PLAY) && data_ce && !abort;
    assign last_rd    = (CNT_W'(rd_addr) == (load_count - CNT_W'(1)));
    assign busy       = (state != IDLE);

    // Completed line: final word goes straight to the top slot, bypassing the pack register
    always_comb begin
        wr_line              = pack_line;
        wr_line[DW-1 -: 32]  = load_data;
    end

    // Simple dual-port RAM, registered read, no reset on contents
    always_ff @(posedge clk_data) begin
        if (line_done) begin
            mem[wr_addr] <= wr_line;
        end
        if (ram_re) begin
            ram_q <= mem[rd_addr];
        end
    end

    // Control FSM, load packing and output register
    always_ff @(posedge clk_data) begin
        if (rst) begin
            state          <= IDLE;
            wr_addr        <= '0;
            rd_addr        <= '0;
            pack_cnt       <= '0;
            pack_line      <= '0;
            loop_q         <= 1'b0;
            rd_vld         <= 1'b0;
            drain_cnt      <= 1'b0;
            load_count     <= '0;
            data_out       <= '0;
            data_out_valid <= 1'b0;
            done           <= 1'b0;
        end else begin
            done           <= 1'b0;
            rd_vld         <= ram_re;
            data_out_valid <= rd_vld && !abort;
            if (rd_vld && !abort) begin
                data_out <= ram_q;
            end

            if (abort) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (clear) begin
                            load_count <= '0;
                            wr_addr    <= '0;
                            pack_cnt   <= '0;
                        end else if (arm && (load_count != '0)) begin
                            pack_cnt <= '0;
                            loop_q   <= loop_en;
                            rd_addr  <= '0;
                            state    <= WAIT_TRIG;
                        end else if (load_acc) begin
                            for (int k = 0; k < int'(WORDS_PER_LINE); k++) begin
                                if (pack_cnt == PACK_W'(k)) begin
                                    pack_line[32*k +: 32] <= load_data;
                                end
                            end
                            if (line_done) begin
                                pack_cnt   <= '0;
                                wr_addr    <= wr_addr + AW'(1);
                                load_count <= load_count + CNT_W'(1);
                            end else begin
                                pack_cnt <= pack_cnt + PACK_W'(1);
                            end
                        end
                    end
                    WAIT_TRIG: begin
                        if (trigger && data_ce) begin
                            state <= PLAY;
                        end
                    end
                    PLAY: begin
                        if (data_ce) begin
                            if (last_rd) begin
                                if (loop_q) begin
                                    rd_addr <= '0;
                                end else begin
                                    state     <= DRAIN;
                                    drain_cnt <= 1'b0;
                                end
                            end else begin
                                rd_addr <= rd_addr + AW'(1);
                            end
                        end
                    end
                    DRAIN: begin
                        // Two cycles lets the final read reach data_out before done
                        if (!drain_cnt) begin
                            drain_cnt <= 1'b1;
                            done      <= 1'b1;
                        end else begin
                            state <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_snapshot_playback.sv
// Directed bench for snapshot_playback with a 4-line RAM and 1024-bit lines.
module tb_snapshot_playback;

    localparam int unsigned DW    = 1024;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned LOG2D = 2;

    logic            clk_data = 1'b0;
    logic            rst;
    logic            load_valid;
    logic [31:0]     load_data;
    logic            load_ready;
    logic            clear;
    logic            arm;
    logic            trigger;
    logic            loop_en;
    logic            abort;
    logic            data_ce;
    logic [DW-1:0]   data_out;
    logic            data_out_valid;
    logic            busy;
    logic            done;
    logic [LOG2D:0]  load_count;

    int checks   = 0;
    int failures = 0;

    logic [DW-1:0] got_lines[$];
    int            got_at[$];
    int            done_at[$];
    logic          busy_log[64];

    snapshot_playback #(
        .DATA_BUS_WIDTH(DW),
        .PLAYBACK_DEPTH(DEPTH),
        .LOG2_PLAYBACK_DEPTH(LOG2D)
    ) dut (
        .clk_data(clk_data),
        .rst(rst),
        .load_valid(load_valid),
        .load_data(load_data),
        .load_ready(load_ready),
        .clear(clear),
        .arm(arm),
        .trigger(trigger),
        .loop_en(loop_en),
        .abort(abort),
        .data_ce(data_ce),
        .data_out(data_out),
        .data_out_valid(data_out_valid),
        .busy(busy),
        .done(done),
        .load_count(load_count)
    );

    always #5 clk_data = ~clk_data;

    // Line whose word j holds base+j (word 0 in the LSBs)
    function automatic logic [DW-1:0] exp_line(input int base);
        logic [DW-1:0] r;
        for (int j = 0; j < 32; j++) r[32*j +: 32] = 32'(base + j);
        return r;
    endfunction

    task automatic step();
        @(posedge clk_data);
        #1;
    endtask

    task automatic load_words(input int n, input int base);
        for (int i = 0; i < n; i++) begin
            load_valid = 1'b1;
            load_data  = 32'(base + i);
            step();
        end
        load_valid = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
    endtask

    task automatic start_play(input logic lp);
        arm     = 1'b1;
        loop_en = lp;
        step();
        arm     = 1'b0;
        trigger = 1'b1;
        data_ce = 1'b1;
        step();
        trigger = 1'b0;
    endtask

    // n=0 is the first PLAY cycle; records valid lines, done pulses and busy per cycle
    task automatic play_collect(input int ncyc, input int ce_period, input int abort_at, input int clear_at);
        got_lines.delete();
        got_at.delete();
        done_at.delete();
        for (int n = 0; n < ncyc; n++) begin
            data_ce = ((n % ce_period) == 0);
            abort   = (n == abort_at);
            clear   = (n == clear_at);
            if (data_out_valid) begin
                got_lines.push_back(data_out);
                got_at.push_back(n);
            end
            if (done) done_at.push_back(n);
            busy_log[n] = busy;
            step();
        end
        data_ce = 1'b0;
        abort   = 1'b0;
        clear   = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        checks++; if (data_out !== '0) begin failures++; $display("FAIL reset_data_out got=%h exp=0", data_out[31:0]); end
        checks++; if (data_out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", data_out_valid); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (load_count !== 3'd0) begin failures++; $display("FAIL reset_load_count got=%0d exp=0", load_count); end
        checks++; if (load_ready !== 1'b1) begin failures++; $display("FAIL reset_load_ready got=%b exp=1", load_ready); end
    endtask

    task automatic test_single_shot();
        logic [DW-1:0] l0;
        load_words(64, 0);
        checks++; if (load_count !== 3'd2) begin failures++; $display("FAIL ss_load_count got=%0d exp=2", load_count); end
        start_play(1'b0);
        play_collect(10, 1, -1, -1);
        checks++; if (got_lines.size() != 2) begin failures++; $display("FAIL ss_nlines got=%0d exp=2", got_lines.size()); end
        if (got_lines.size() >= 2) begin
            l0 = got_lines[0];
            checks++; if (got_at[0] != 2 || got_at[1] != 3) begin failures++; $display("FAIL ss_valid_timing got=%0d,%0d exp=2,3", got_at[0], got_at[1]); end
            checks++; if (l0[31:0] !== 32'd0) begin failures++; $display("FAIL ss_line0_lsw got=%0d exp=0", l0[31:0]); end
            checks++; if (l0[1023:992] !== 32'd31) begin failures++; $display("FAIL ss_line0_msw got=%0d exp=31", l0[1023:992]); end
            checks++; if (got_lines[1] !== exp_line(32)) begin failures++; $display("FAIL ss_line1 got_lsw=%0d exp_lsw=32", got_lines[1][31:0]); end
        end
        checks++; if (done_at.size() != 1 || (done_at.size() == 1 && done_at[0] != 3)) begin failures++; $display("FAIL ss_done npulses=%0d exp 1 pulse at cycle 3", done_at.size()); end
        checks++; if (busy_log[3] !== 1'b1 || busy_log[4] !== 1'b0) begin failures++; $display("FAIL ss_busy_drop got=%b%b exp=10", busy_log[3], busy_log[4]); end
    endtask

    task automatic test_strobe_spacing();
        int ok;
        do_clear();
        load_words(128, 1000);
        checks++; if (load_count !== 3'd4 || load_ready !== 1'b0) begin failures++; $display("FAIL sp_full got_count=%0d got_ready=%b exp=4,0", load_count, load_ready); end
        start_play(1'b0);
        play_collect(16, 3, -1, -1);
        checks++; if (got_lines.size() != 4) begin failures++; $display("FAIL sp_nlines got=%0d exp=4", got_lines.size()); end
        ok = 1;
        for (int k = 0; k < got_lines.size() && k < 4; k++) begin
            if (got_at[k] != 3*k + 2 || got_lines[k] !== exp_line(1000 + 32*k)) ok = 0;
        end
        checks++; if (ok == 0) begin failures++; $display("FAIL sp_order_timing got_first_at=%0d exp_at=2,5,8,11", got_at.size() > 0 ? got_at[0] : -1); end
        checks++; if (done_at.size() != 1 || (done_at.size() == 1 && done_at[0] != 11)) begin failures++; $display("FAIL sp_done npulses=%0d exp 1 at cycle 11", done_at.size()); end
    endtask

    task automatic test_loop_abort();
        int ok;
        int n7;
        do_clear();
        load_words(96, 2000);
        start_play(1'b1);
        play_collect(10, 1, 9, -1);
        checks++; if (data_out_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL la_abort_next got_valid=%b got_busy=%b exp=0,0", data_out_valid, busy); end
        ok = 1;
        n7 = 0;
        for (int k = 0; k < got_lines.size(); k++) begin
            if (got_at[k] <= 8) begin
                n7++;
                if (got_at[k] != k + 2 || got_lines[k] !== exp_line(2000 + 32*(k % 3))) ok = 0;
            end
        end
        checks++; if (n7 != 7 || ok == 0) begin failures++; $display("FAIL la_order got_n=%0d ok=%0d exp=7 lines 0,1,2,0,1,2,0", n7, ok); end
        play_collect(4, 1, -1, -1);
        checks++; if (got_lines.size() != 0 || done_at.size() != 0) begin failures++; $display("FAIL la_after_abort got_valid=%0d got_done=%0d exp=0,0", got_lines.size(), done_at.size()); end
        checks++; if (load_count !== 3'd3) begin failures++; $display("FAIL la_load_count got=%0d exp=3", load_count); end
    endtask

    task automatic test_overflow_partial();
        int ready_seen;
        do_clear();
        ready_seen = 0;
        for (int i = 0; i < 4*32 + 5; i++) begin
            load_valid = 1'b1;
            load_data  = 32'(i);
            if (load_ready) ready_seen++;
            step();
            if (i == 127) begin
                checks++; if (load_ready !== 1'b0) begin failures++; $display("FAIL ov_ready_after_128 got=%b exp=0", load_ready); end
            end
        end
        load_valid = 1'b0;
        checks++; if (ready_seen != 128 || load_count !== 3'd4) begin failures++; $display("FAIL ov_accepted got_ready=%0d got_count=%0d exp=128,4", ready_seen, load_count); end
        do_clear();
        load_words(40, 3000);
        checks++; if (load_count !== 3'd1) begin failures++; $display("FAIL pt_load_count got=%0d exp=1", load_count); end
        start_play(1'b0);
        play_collect(8, 1, -1, -1);
        checks++; if (got_lines.size() != 1 || (got_lines.size() == 1 && got_lines[0] !== exp_line(3000))) begin failures++; $display("FAIL pt_one_line got_n=%0d exp=1 line base 3000", got_lines.size()); end
        load_words(32, 5000);
        start_play(1'b0);
        play_collect(8, 1, -1, -1);
        checks++; if (got_lines.size() != 2 || (got_lines.size() == 2 && got_lines[1] !== exp_line(5000))) begin failures++; $display("FAIL pt_discarded got_n=%0d got_lsw=%0d exp=2 lines, line1 lsw 5000", got_lines.size(), got_lines.size() == 2 ? got_lines[1][31:0] : 32'd0); end
    endtask

    task automatic test_ignored_cmds();
        int vcnt;
        do_clear();
        arm = 1'b1;
        step();
        arm = 1'b0;
        checks++; if (busy !== 1'b0 || load_count !== 3'd0) begin failures++; $display("FAIL ig_arm_empty got_busy=%b got_count=%0d exp=0,0", busy, load_count); end
        load_words(64, 6000);
        arm = 1'b1;
        loop_en = 1'b0;
        step();
        arm = 1'b0;
        vcnt = 0;
        trigger = 1'b1;
        data_ce = 1'b0;
        for (int i = 0; i < 3; i++) begin step(); if (data_out_valid) vcnt++; end
        trigger = 1'b0;
        data_ce = 1'b1;
        for (int i = 0; i < 3; i++) begin step(); if (data_out_valid) vcnt++; end
        checks++; if (vcnt != 0 || busy !== 1'b1) begin failures++; $display("FAIL ig_wait_trig got_valid=%0d got_busy=%b exp=0,1", vcnt, busy); end
        trigger = 1'b1;
        step();
        trigger = 1'b0;
        play_collect(8, 1, -1, 0);
        checks++; if (got_lines.size() != 2 || load_count !== 3'd2) begin failures++; $display("FAIL ig_clear_in_play got_n=%0d got_count=%0d exp=2,2", got_lines.size(), load_count); end
        if (got_lines.size() == 2) begin
            checks++; if (got_lines[0] !== exp_line(6000) || got_lines[1] !== exp_line(6032)) begin failures++; $display("FAIL ig_lines got_lsw=%0d,%0d exp=6000,6032", got_lines[0][31:0], got_lines[1][31:0]); end
        end
    endtask

    task automatic test_reset_mid_play();
        start_play(1'b1);
        data_ce = 1'b1;
        step();
        step();
        step();
        rst = 1'b1;
        step();
        checks++; if (data_out !== '0 || data_out_valid !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL rm_outputs got_valid=%b got_done=%b got_busy=%b exp all 0", data_out_valid, done, busy); end
        checks++; if (load_count !== 3'd0 || load_ready !== 1'b1) begin failures++; $display("FAIL rm_load got_count=%0d got_ready=%b exp=0,1", load_count, load_ready); end
        rst     = 1'b0;
        data_ce = 1'b0;
        step();
    endtask

    initial begin
        rst        = 1'b1;
        load_valid = 1'b0;
        load_data  = '0;
        clear      = 1'b0;
        arm        = 1'b0;
        trigger    = 1'b0;
        loop_en    = 1'b0;
        abort      = 1'b0;
        data_ce    = 1'b0;
        test_reset();
        test_single_shot();
        test_strobe_spacing();
        test_loop_abort();
        test_overflow_partial();
        test_ignored_cmds();
        test_reset_mid_play();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
